// File: rtl/synch_fifo_reader.sv
// ============================================================================
// Module   : synch_fifo_reader
// Purpose  : Read-side engine for the synchronous FIFO; hides the one-cycle
//            read latency behind a 3-entry buffer and presents valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module synch_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_re,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    logic [DATA_WIDTH-1:0] mem [0:2];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            count;
    logic                  pending;
    logic                  pop;
    logic [2:0]            committed;

    // Reads in flight count against capacity so a full backlog never overflows.
    assign committed = {1'b0, count} + {2'b00, pending};
    assign fifo_re   = !reset && en && !fifo_empty && (committed < 3'd3);

    assign m_valid   = (count != 2'd0);
    assign m_data    = mem[head];
    assign buf_level = count;
    assign pop       = m_valid && m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= 2'd0;
            tail       <= 2'd0;
            count      <= 2'd0;
            pending    <= 1'b0;
            xfer_count <= '0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pending <= fifo_re;
            if (pending) begin
                mem[tail] <= fifo_data_out;
                tail      <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
            end
            if (pop) begin
                head       <= (head == 2'd2) ? 2'd0 : head + 2'd1;
                xfer_count <= xfer_count + 1'b1;
            end
            case ({pending, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/synch_fifo_reader.md
Name: synch_fifo_reader

Overview:
- Read-side engine for the synchronous FIFO. It drives the FIFO's read port (`re`, `data_out`, `empty`) and re-presents the words on a valid/ready stream.
- Absorbs the FIFO's one-cycle read latency with a 3-entry output buffer. This gives one word per clock while downstream is ready, with no underflow and no overflow under backpressure.
- Sits between the FIFO and any downstream consumer. It is the reader counterpart of the write-side stimulus already used on the FIFO.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- CNT_WIDTH, 16, width of the transferred-word counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  when 1, the block may issue new FIFO reads; when 0, no new reads are issued.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid in the cycle after a read is sampled.
- fifo_re  output  1  FIFO read enable.
- m_valid  output  1  stream word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_WIDTH  stream word (head of the buffer).
- buf_level  output  2  number of occupied buffer entries, 0..3.
- xfer_count  output  CNT_WIDTH  number of completed stream transfers, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, immediate, held while `reset`=1):
  - `fifo_re`=0, `m_valid`=0, `m_data`=0, `buf_level`=0, `xfer_count`=0.
  - Pending-read flag cleared; all buffer entries cleared.
- Internal state:
  - 3-entry circular buffer with head/tail pointers, each wrapping 2→0.
  - `count` (0..3).
  - `pending` (1 bit): a read was issued last cycle and its data arrives this cycle.
- Read issue (combinational from registered state and `fifo_empty` only):
  - `fifo_re` = `en` && !`fifo_empty` && (`count` + `pending`) < 3.
  - There is no combinational path from `m_ready` to `fifo_re`.
  - `fifo_re` is never 1 while `fifo_empty`=1, so the FIFO never underflows.
- Pending flag: `pending` <= `fifo_re` each edge.
- Capture: at an edge with `pending`=1, `fifo_data_out` is written to the buffer tail, tail advances, and `count` increments.
- Pop:
  - `m_valid` = (`count` != 0).
  - `m_data` = buffer head entry, held stable while `m_valid`=1 and `m_ready`=0.
  - At an edge with `m_valid`&&`m_ready`: head advances, `count` decrements, `xfer_count` increments.
- Simultaneous capture and pop:
  - `count` is unchanged and order is preserved.
  - When `count`=1, the new word becomes the head after the edge with no bubble.
- Latency:
  - `fifo_empty` falls in cycle k with `en`=1 and the buffer not full → `fifo_re`=1 in cycle k.
  - Word captured at the end of cycle k+1; `m_valid`=1 in cycle k+2.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty and `m_ready`=1. Steady state is `count`=1 with `pending`=1.
- Backpressure: with `m_ready`=0, at most 3 reads are outstanding or buffered. `buf_level` saturates at 3 with no data loss.
- Order: stream order equals FIFO read order, always.
- `en` deassertion:
  - Takes effect in the same cycle; no new `fifo_re`.
  - An in-flight read (`pending`) still completes capture.
  - Buffered words continue to drain.
- `buf_level` = `count`.
- `xfer_count` wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - `fifo_re` drops immediately (asynchronously).
  - Normal operation resumes on the first edge after `reset` is released.

Test Plan:
1. Reset with `fifo_empty`=1 → all outputs 0; `fifo_re` stays 0 for 10 cycles with `en`=1.
2. One word 0xA5A50001 in the FIFO, `m_ready`=1 → one `fifo_re` pulse in cycle k; `m_valid`=1 with `m_data`=0xA5A50001 in cycle k+2 for exactly 1 cycle; `xfer_count`=1.
3. 8 words 0x10..0x17, `m_ready`=1 → `fifo_re` high 8 consecutive cycles; `m_valid` high 8 consecutive cycles; data 0x10..0x17 in order; `xfer_count`=8.
4. 5 words 0x20..0x24, `m_ready`=0 → exactly 3 `fifo_re` pulses; `buf_level`=3; `m_data`=0x20 held. Then `m_ready`=1 → 0x20..0x24 delivered in order, no gaps after the first.
5. 8 words in the FIFO, `en` dropped after the 3rd `fifo_re` → no further `fifo_re`; exactly 3 words delivered (0x30..0x32); `buf_level` returns to 0.
6. `reset` pulsed mid-burst with `buf_level`=2 → outputs 0 immediately; after release, the next word read from the FIFO is the first delivered.
7. CNT_WIDTH=4, 17 transfers → `xfer_count`=1.
